// File: rtl/univ_register_pkg.sv
// Shared types for the universal register: operation select encoding.
package univ_register_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROTL = 3'd4,
    ROTR = 3'd5,
    INC  = 3'd6,
    DEC  = 3'd7
  } mode_t;

endpackage

// File: rtl/univ_register_next.sv
// Combinational next-state logic for univ_register: computes next Q and cout per mode.
module univ_register_next
  import univ_register_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  input  logic         sin,
  input  mode_t        mode,
  input  logic         cur_cout,
  output logic [N-1:0] q_next,
  output logic         cout_next
);

  logic [N:0] inc_sum;

  assign inc_sum = {1'b0, q} + {{N{1'b0}}, 1'b1};

  always_comb begin
    q_next    = q;
    cout_next = cur_cout;
    unique case (mode)
      HOLD: begin
        q_next    = q;
        cout_next = cur_cout;
      end
      LOAD: begin
        q_next    = d;
        cout_next = 1'b0;
      end
      SHL: begin
        q_next    = {q[N-2:0], sin};
        cout_next = q[N-1];
      end
      SHR: begin
        q_next    = {sin, q[N-1:1]};
        cout_next = q[0];
      end
      ROTL: begin
        q_next    = {q[N-2:0], q[N-1]};
        cout_next = q[N-1];
      end
      ROTR: begin
        q_next    = {q[0], q[N-1:1]};
        cout_next = q[0];
      end
      INC: begin
        q_next    = inc_sum[N-1:0];
        cout_next = inc_sum[N];
      end
      DEC: begin
        // borrow out is exactly the wrap from zero to all-ones
        q_next    = q - {{(N-1){1'b0}}, 1'b1};
        cout_next = (q == '0);
      end
      default: begin
        q_next    = q;
        cout_next = cur_cout;
      end
    endcase
  end

endmodule

// File: rtl/univ_register.sv
// N-bit universal datapath register: load, shift, rotate, count with carry and zero flags.
module univ_register
  import univ_register_pkg::*;
#(
  parameter int          N         = 4,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      D,
  input  logic              sin,
  output logic [N-1:0]      Q,
  output logic              cout,
  output logic              zero
);

  logic [N-1:0] q_next;
  logic         cout_next;

  univ_register_next #(
    .N (N)
  ) u_next (
    .q         (Q),
    .d         (D),
    .sin       (sin),
    .mode      (mode_t'(mode)),
    .cur_cout  (cout),
    .q_next    (q_next),
    .cout_next (cout_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q    <= RESET_VAL;
      cout <= 1'b0;
    end else if (en) begin
      Q    <= q_next;
      cout <= cout_next;
    end
  end

  assign zero = (Q == '0);

endmodule

// File: tb/tb_univ_register.sv
// Self-checking bench for univ_register: directed plan plus randomized ops vs. an arithmetic model.
module tb_univ_register;
  import univ_register_pkg::*;

  localparam int N   = 4;
  localparam int MOD = 1 << N;
  localparam int RVC = 12;

  logic         clk;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [N-1:0] D;
  logic         sin;
  logic [N-1:0] q0, qc;
  logic         cout0, coutc, zero0, zeroc;

  int n_checks;
  int n_fail;
  int mq0, mc0, mqc, mcc;

  univ_register #(.N(N), .RESET_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(D), .sin(sin),
    .Q(q0), .cout(cout0), .zero(zero0)
  );

  univ_register #(.N(N), .RESET_VAL(4'hC)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(D), .sin(sin),
    .Q(qc), .cout(coutc), .zero(zeroc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns cout*MOD + q after one enabled operation.
  function automatic int model(input int m, input int q, input int c, input int d, input int s);
    int nq, nc;
    case (m)
      0: begin nq = q;                         nc = c;              end
      1: begin nq = d;                         nc = 0;              end
      2: begin nq = (q * 2 + s) % MOD;         nc = q / (MOD / 2);  end
      3: begin nq = q / 2 + s * (MOD / 2);     nc = q % 2;          end
      4: begin nq = (q * 2) % MOD + q / (MOD / 2); nc = q / (MOD / 2); end
      5: begin nq = q / 2 + (q % 2) * (MOD / 2); nc = q % 2;        end
      6: begin nq = (q + 1) % MOD;             nc = (q == MOD - 1) ? 1 : 0; end
      default: begin nq = (q + MOD - 1) % MOD; nc = (q == 0) ? 1 : 0; end
    endcase
    return nc * MOD + nq;
  endfunction

  task automatic check_all();
    check("q0", q0, mq0);
    check("cout0", cout0, mc0);
    check("zero0", zero0, (mq0 == 0) ? 1 : 0);
    check("qc", qc, mqc);
    check("coutc", coutc, mcc);
    check("zeroc", zeroc, (mqc == 0) ? 1 : 0);
  endtask

  task automatic model_reset();
    mq0 = 0;   mc0 = 0;
    mqc = RVC; mcc = 0;
  endtask

  // Called at a negedge: apply inputs, clock once, check at the next negedge.
  task automatic step(input logic e, input logic [2:0] m, input logic [N-1:0] d, input logic s);
    int r;
    en = e; mode = m; D = d; sin = s;
    @(posedge clk);
    if (e) begin
      r = model(int'(m), mq0, mc0, int'(d), int'(s)); mq0 = r % MOD; mc0 = r / MOD;
      r = model(int'(m), mqc, mcc, int'(d), int'(s)); mqc = r % MOD; mcc = r / MOD;
    end
    @(negedge clk);
    check_all();
  endtask

  // Mid-cycle asynchronous reset pulse, checked before any clock edge.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; mode = 3'd0; D = '0; sin = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset from Q=7, then held across an edge
    step(1'b1, LOAD, 4'h7, 1'b0);
    check("tp_load7", q0, 4'h7);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("tp_rst_q", q0, 4'h0);
    check("tp_rst_cout", cout0, 1'b0);
    check("tp_rst_zero", zero0, 1'b1);
    check("tp_rst_qc", qc, 4'hC);
    en = 1'b1; mode = INC;
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    step(1'b1, LOAD, 4'hA, 1'b0); check("tp_loadA", q0, 4'hA);
    step(1'b0, LOAD, 4'h3, 1'b0); check("tp_en0_a", q0, 4'hA);
    step(1'b0, LOAD, 4'h3, 1'b0); check("tp_en0_b", q0, 4'hA);
    step(1'b1, SHL, 4'h0, 1'b1);  check("tp_shl", q0, 4'h5);  check("tp_shl_c", cout0, 1'b1);
    step(1'b1, SHR, 4'h0, 1'b0);  check("tp_shr0", q0, 4'h2); check("tp_shr0_c", cout0, 1'b1);
    step(1'b1, SHR, 4'h0, 1'b1);  check("tp_shr1", q0, 4'h9); check("tp_shr1_c", cout0, 1'b0);
    step(1'b1, ROTL, 4'h0, 1'b0); check("tp_rotl", q0, 4'h3); check("tp_rotl_c", cout0, 1'b1);
    step(1'b1, ROTR, 4'h0, 1'b0); check("tp_rotr", q0, 4'h9); check("tp_rotr_c", cout0, 1'b1);
    step(1'b1, HOLD, 4'h0, 1'b0); check("tp_hold", q0, 4'h9); check("tp_hold_c", cout0, 1'b1);
    step(1'b1, LOAD, 4'hF, 1'b0);
    step(1'b1, INC, 4'h0, 1'b0);  check("tp_incwrap", q0, 4'h0); check("tp_incwrap_c", cout0, 1'b1);
    check("tp_incwrap_z", zero0, 1'b1);
    step(1'b1, DEC, 4'h0, 1'b0);  check("tp_decwrap", q0, 4'hF); check("tp_decwrap_c", cout0, 1'b1);
    step(1'b1, LOAD, 4'h5, 1'b0);
    step(1'b1, INC, 4'h0, 1'b0);  check("tp_inc5", q0, 4'h6); check("tp_inc5_c", cout0, 1'b0);
    check("tp_inc5_z", zero0, 1'b0);

    // reset aborts an INC run
    step(1'b1, LOAD, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, INC, 4'h0, 1'b0);
    check("tp_run3", q0, 4'h3);
    reset_pulse();
    check("tp_abort_q0", q0, 4'h0);
    check("tp_abort_qc", qc, 4'hC);
    step(1'b1, INC, 4'h0, 1'b0);
    check("tp_after_q0", q0, 4'h1);
    check("tp_after_qc", qc, 4'hD);

    // randomized operations with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) reset_pulse();
      step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, MOD - 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
